gshare_branch_predictor: RTL
============================

Name: gshare_branch_predictor

Overview:
Parametrised next-generation correlating branch predictor. It holds a pattern history table (PHT) of N-bit saturating counters and a speculative global history register (GHR). The PHT is indexed by the PC, either concatenated or XOR-hashed with the GHR. The fetch side gets a registered prediction. The execute side writes back resolved outcomes and repairs history on a mispredict. The PHT is cleared in hardware after reset, not left at X.

Parameters:
M, 2, global history length in bits (0 = pure bimodal)
N, 2, counter width in bits (N >= 1)
R, 8, PC index bits, taken from PC[R+1:2]
HASH_MODE, 0, 0 = index {PC bits, GHR}; 1 = index PC bits XOR zero-extended GHR (requires M <= R)

Ports:
Clk  input  1  clock, all state on posedge
Reset  input  1  synchronous active-high reset
Pred_valid  input  1  prediction request this cycle
Pred_pc  input  32  PC of branch being predicted
Pred_taken  output  1  prediction, valid one cycle after the request
Pred_ack  output  1  high when Pred_taken is valid
Pred_hist  output  M (min 1)  GHR value used for this prediction; carried down the pipe
Upd_valid  input  1  resolved branch this cycle
Upd_pc  input  32  PC of resolved branch
Upd_hist  input  M (min 1)  Pred_hist returned with the branch
Upd_taken  input  1  actual outcome
Upd_mispredict  input  1  prediction was wrong; repair GHR
Busy  output  1  high while the PHT is being cleared; requests are ignored

Behaviour:
- Index width IW = R+M in mode 0 and R in mode 1. The PHT has 2^IW entries.
- Init value is WNT = 2^(N-1)-1. Prediction = counter MSB.
- Reset (any cycle, including mid-operation): GHR=0, Pred_ack=0, Pred_taken=0, Pred_hist=0, Busy=1. The FSM enters CLEAR with its pointer at 0.
- CLEAR state: writes WNT to entry ptr, one entry per cycle. Goes to RUN after entry 2^IW-1, so Busy is high for exactly 2^IW cycles after Reset falls. Pred_valid and Upd_valid are ignored.
- RUN, predict: when Pred_valid, read PHT[idx(Pred_pc,GHR)].
  - Next cycle: Pred_ack=1, Pred_taken=MSB, Pred_hist=GHR as it was before the shift.
  - In the same edge the GHR shifts speculatively: GHR <= {GHR[M-2:0], predicted bit}.
  - Pred_ack is a single-cycle pulse per request. Back-to-back requests are supported, one per cycle.
- RUN, update: when Upd_valid, index = idx(Upd_pc,Upd_hist). Read-modify-write the counter, all in one cycle:
  - +1 if taken, saturating at 2^N-1.
  - -1 if not taken, saturating at 0.
- Mispredict repair: when Upd_valid && Upd_mispredict, GHR <= {Upd_hist[M-2:0], Upd_taken}. This takes priority over any speculative shift from a same-cycle Pred_valid.
- Same-cycle predict and update to the same index: the prediction reads the pre-update value (read-before-write). The update is committed.
- M == 0: no GHR. Pred_hist is tied to 0 and the repair logic is absent.
- Width rules: GHR and counters never wrap; only saturate or shift. Upd_mispredict without Upd_valid is ignored.

Decomposition:
- Package bp_pkg holds:
  - function idx(pc, hist, mode) returning the IW-bit index
  - function sat_inc/sat_dec on N bits
  - WNT constant expression
  - FSM enum {CLEAR, RUN}
- One natural sub-module: bp_pht, a 2^IW x N single-write, dual-read register array with sync clear pointer support.

Test Plan:
- Init: assert Reset 1 cycle, release -> Busy high exactly 256*4=1024 cycles (M=2,R=8). Then predicting any PC gives Pred_taken=0; a backdoor read shows every entry = 2'b01.
- Saturation: 3 updates PC=0x40, hist=0, taken -> counter 01->10->11->11. Prediction then returns 1. Then 4 not-taken updates -> 00, and the prediction returns 0.
- Correlation: alternate outcome pattern T,N,T,N on PC=0x80, updates fed with matching Upd_hist, 40 iterations -> last 8 predictions 100% correct (distinct entries for hist 01/10).
- Speculative history and repair: two predictions with GHR=00 give Pred_hist=00 then 00|pred. Then Upd_mispredict with Upd_hist=00, Upd_taken=1 -> next Pred_hist=01.
- Same-cycle collision: predict and taken-update on the same index holding 01 -> Pred_taken=0. A following predict returns 1.
- HASH_MODE=1 with reset mid-run: hold Reset high during traffic -> outputs zero next edge; Busy lasts 256 cycles; PC=0x04, GHR=01 hits index 0 (1^1).

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: PHT index hashing,
// saturating counter arithmetic and the weakly-not-taken init value.
package bp_pkg;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   // Weakly-not-taken value for an n-bit counter: MSB clear, all lower bits set.
   function automatic logic [31:0] wnt(input int unsigned n);
      return (32'd1 << (n - 1)) - 32'd1;
   endfunction

   function automatic logic [31:0] idx(input logic [31:0] pc, input logic [31:0] hist,
                                       input int unsigned mode, input int unsigned m,
                                       input int unsigned r);
      logic [31:0] pcb;
      logic [31:0] h;
      pcb = (pc >> 2) & ((32'd1 << r) - 32'd1);
      h   = hist & ((32'd1 << m) - 32'd1);
      if (mode == 0)
         return (pcb << m) | h;
      return pcb ^ h;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c, input int unsigned n);
      logic [31:0] max_v;
      max_v = (32'd1 << n) - 32'd1;
      return (c >= max_v) ? max_v : c + 32'd1;
   endfunction

   function automatic logic [31:0] sat_dec(input logic [31:0] c);
      return (c == 32'd0) ? 32'd0 : c - 32'd1;
   endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IW x N counter array, one write port shared between
// the clear sequencer and branch updates, two asynchronous read ports.
module bp_pht #(
   parameter int N  = 2,
   parameter int IW = 10
) (
   input  logic          Clk,
   input  logic          clr_en,
   input  logic [IW-1:0] clr_ptr,
   input  logic [N-1:0]  clr_val,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [N-1:0]  wr_data,
   input  logic [IW-1:0] rd_a_idx,
   output logic [N-1:0]  rd_a,
   input  logic [IW-1:0] rd_b_idx,
   output logic [N-1:0]  rd_b
);

   logic [N-1:0] mem [2**IW];

   // Clearing owns the write port; updates are dropped until the table is initialised.
   always_ff @(posedge Clk) begin
      if (clr_en)
         mem[clr_ptr] <= clr_val;
      else if (wr_en)
         mem[wr_idx] <= wr_data;
   end

   assign rd_a = mem[rd_a_idx];
   assign rd_b = mem[rd_b_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare / bimodal branch predictor with speculative global history, mispredict
// repair and a hardware clear of the PHT after every reset.
module gshare_branch_predictor
   import bp_pkg::*;
#(
   parameter int M         = 2,
   parameter int N         = 2,
   parameter int R         = 8,
   parameter int HASH_MODE = 0,
   localparam int HW       = (M == 0) ? 1 : M,
   localparam int IW       = (HASH_MODE == 0) ? R + M : R
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Pred_valid,
   input  logic [31:0]   Pred_pc,
   output logic          Pred_taken,
   output logic          Pred_ack,
   output logic [HW-1:0] Pred_hist,
   input  logic          Upd_valid,
   input  logic [31:0]   Upd_pc,
   input  logic [HW-1:0] Upd_hist,
   input  logic          Upd_taken,
   input  logic          Upd_mispredict,
   output logic          Busy
);

   state_t        state;
   logic [IW-1:0] clr_ptr;
   logic [HW-1:0] ghr;
   logic [IW-1:0] pred_idx_p0;
   logic [IW-1:0] upd_idx_p0;
   logic [N-1:0]  pred_ctr_p0;
   logic [N-1:0]  upd_ctr_p0;
   logic [N-1:0]  upd_next_p0;
   logic          pred_bit_p0;
   logic          clr_en;
   logic          wr_en;

   assign pred_idx_p0 = IW'(idx(Pred_pc, 32'(ghr), HASH_MODE, M, R));
   assign upd_idx_p0  = IW'(idx(Upd_pc, 32'(Upd_hist), HASH_MODE, M, R));
   assign pred_bit_p0 = pred_ctr_p0[N-1];
   assign upd_next_p0 = Upd_taken ? N'(sat_inc(32'(upd_ctr_p0), N))
                                  : N'(sat_dec(32'(upd_ctr_p0)));
   assign clr_en      = (state == CLEAR);
   assign wr_en       = (state == RUN) && Upd_valid;

   bp_pht #(.N(N), .IW(IW)) u_pht (
      .Clk      (Clk),
      .clr_en   (clr_en),
      .clr_ptr  (clr_ptr),
      .clr_val  (N'(wnt(N))),
      .wr_en    (wr_en),
      .wr_idx   (upd_idx_p0),
      .wr_data  (upd_next_p0),
      .rd_a_idx (pred_idx_p0),
      .rd_a     (pred_ctr_p0),
      .rd_b_idx (upd_idx_p0),
      .rd_b     (upd_ctr_p0)
   );

   // p0 -> p1: registered prediction and history bookkeeping
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= CLEAR;
         clr_ptr    <= '0;
         Busy       <= 1'b1;
         Pred_ack   <= 1'b0;
         Pred_taken <= 1'b0;
         Pred_hist  <= '0;
         ghr        <= '0;
      end else begin
         case (state)
            CLEAR: begin
               Pred_ack <= 1'b0;
               clr_ptr  <= clr_ptr + IW'(1);
               if (clr_ptr == '1) begin
                  state <= RUN;
                  Busy  <= 1'b0;
               end
            end
            RUN: begin
               Pred_ack <= Pred_valid;
               if (Pred_valid) begin
                  Pred_taken <= pred_bit_p0;
                  Pred_hist  <= ghr;
               end
               // Repair from the resolved branch wins over a same-cycle speculative shift.
               if (M > 0) begin
                  if (Upd_valid && Upd_mispredict)
                     ghr <= (Upd_hist << 1) | HW'(Upd_taken);
                  else if (Pred_valid)
                     ghr <= (ghr << 1) | HW'(pred_bit_p0);
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
